// File: rtl/fir_command_sequencer.sv
// Packet command sequencer between the SPI slave and the FIR filter: decodes
// 64-bit packets into filter runs, coefficient writes and status operations.
module fir_command_sequencer #(
    parameter int unsigned PACKET_SIZE     = 8,
    parameter int unsigned SAMPLES_NUM     = 2,
    parameter int unsigned SAMPLE_WIDTH    = 16,
    parameter int unsigned COEF_ADDR_WIDTH = 6,
    parameter int unsigned COEF_NUM        = 64,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic                                clkIn,
    input  logic                                nResetIn,
    input  logic                                packetValidIn,
    input  logic [8*PACKET_SIZE-1:0]            packetIn,
    output logic                                firStartOut,
    output logic [SAMPLES_NUM*SAMPLE_WIDTH-1:0] firDataOut,
    input  logic                                firDoneIn,
    input  logic [8*PACKET_SIZE-1:0]            firResultIn,
    output logic                                coefWeOut,
    output logic [COEF_ADDR_WIDTH-1:0]          coefAddrOut,
    output logic [SAMPLE_WIDTH-1:0]             coefDataOut,
    output logic [8*PACKET_SIZE-1:0]            responseOut,
    output logic                                busyOut
);
    localparam int unsigned     PW         = 8 * PACKET_SIZE;
    localparam int unsigned     WD_W       = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST    = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [8:0]      COEF_LIMIT = 9'(COEF_NUM);
    localparam logic [7:0]      OP_FILTER  = 8'h01;
    localparam logic [7:0]      OP_COEF    = 8'h02;
    localparam logic [7:0]      OP_STATUS  = 8'h03;
    localparam logic [7:0]      OP_CLEAR   = 8'h04;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_DONE,
        S_COEF_WR,
        S_RESP
    } state_t;

    state_t                              state_q;
    logic                                pend_valid_q;
    logic [PW-1:0]                       pend_q;
    logic                                fir_start_q;
    logic [SAMPLES_NUM*SAMPLE_WIDTH-1:0] fir_data_q;
    logic                                coef_we_q;
    logic [COEF_ADDR_WIDTH-1:0]          coef_addr_q;
    logic [SAMPLE_WIDTH-1:0]             coef_data_q;
    logic [PW-1:0]                       response_q;
    logic [WD_W-1:0]                     wdog_q;
    logic                                flag_overrun_q;
    logic                                flag_illegal_q;
    logic                                flag_timeout_q;
    logic [15:0]                         frame_cnt_q;
    logic [7:0]                          drop_cnt_q;
    logic [7:0]                          illegal_cnt_q;

    logic [PW-1:0]           pkt;
    logic                    accept;
    logic [7:0]              opcode;
    logic [7:0]              arg;
    logic [SAMPLE_WIDTH-1:0] samp0;
    logic [SAMPLE_WIDTH-1:0] samp1;
    logic                    addr_ok;
    logic                    is_illegal;
    logic [PW-1:0]           status_word;
    logic                    unused_pkt_bits;

    // The pending slot always has priority over a packet arriving the same cycle.
    always_comb begin
        pkt        = pend_valid_q ? pend_q : packetIn;
        accept     = (state_q == S_IDLE) && (pend_valid_q || packetValidIn);
        opcode     = pkt[PW-1 -: 8];
        arg        = pkt[PW-9 -: 8];
        samp0      = pkt[PW-17 -: SAMPLE_WIDTH];
        samp1      = pkt[PW-17-SAMPLE_WIDTH -: SAMPLE_WIDTH];
        addr_ok    = ({1'b0, arg} < COEF_LIMIT);
        is_illegal = accept && ((opcode == OP_COEF) ? !addr_ok :
                                !(opcode inside {OP_FILTER, OP_STATUS, OP_CLEAR}));
        status_word = {8'h5A, 4'h0, pend_valid_q, flag_timeout_q, flag_illegal_q,
                       flag_overrun_q, frame_cnt_q, drop_cnt_q, illegal_cnt_q,
                       {(PW-48){1'b0}}};
    end

    assign unused_pkt_bits = ^pkt[PW-17-2*SAMPLE_WIDTH:0];

    always_ff @(posedge clkIn or negedge nResetIn) begin
        if (!nResetIn) begin
            state_q        <= S_IDLE;
            pend_valid_q   <= 1'b0;
            pend_q         <= '0;
            fir_start_q    <= 1'b0;
            fir_data_q     <= '0;
            coef_we_q      <= 1'b0;
            coef_addr_q    <= '0;
            coef_data_q    <= '0;
            response_q     <= '0;
            wdog_q         <= '0;
            flag_overrun_q <= 1'b0;
            flag_illegal_q <= 1'b0;
            flag_timeout_q <= 1'b0;
            frame_cnt_q    <= '0;
            drop_cnt_q     <= '0;
            illegal_cnt_q  <= '0;
        end else begin
            fir_start_q <= 1'b0;
            coef_we_q   <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (accept && !is_illegal) begin
                        case (opcode)
                            OP_FILTER: begin
                                fir_data_q  <= {samp0, samp1};
                                fir_start_q <= 1'b1;
                                state_q     <= S_START;
                            end
                            OP_COEF: begin
                                coef_addr_q <= arg[COEF_ADDR_WIDTH-1:0];
                                coef_data_q <= samp0;
                                coef_we_q   <= 1'b1;
                                state_q     <= S_COEF_WR;
                            end
                            OP_STATUS: begin
                                response_q <= status_word;
                                state_q    <= S_RESP;
                            end
                            default: begin
                                flag_overrun_q <= 1'b0;
                                flag_illegal_q <= 1'b0;
                                flag_timeout_q <= 1'b0;
                                frame_cnt_q    <= '0;
                                drop_cnt_q     <= '0;
                                illegal_cnt_q  <= '0;
                                response_q     <= '0;
                            end
                        endcase
                    end
                end
                S_START: begin
                    wdog_q  <= '0;
                    state_q <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (firDoneIn) begin
                        response_q  <= firResultIn;
                        frame_cnt_q <= frame_cnt_q + 16'd1;
                        state_q     <= S_IDLE;
                    end else if (wdog_q == WD_LAST) begin
                        flag_timeout_q <= 1'b1;
                        state_q        <= S_IDLE;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            if (is_illegal) begin
                flag_illegal_q <= 1'b1;
                if (illegal_cnt_q != '1) illegal_cnt_q <= illegal_cnt_q + 8'd1;
            end

            // In IDLE a full slot drains this edge, so a new packet refills it without a drop.
            if (state_q == S_IDLE) begin
                if (pend_valid_q) begin
                    pend_valid_q <= packetValidIn;
                    if (packetValidIn) pend_q <= packetIn;
                end
            end else if (packetValidIn) begin
                if (!pend_valid_q) begin
                    pend_valid_q <= 1'b1;
                    pend_q       <= packetIn;
                end else begin
                    flag_overrun_q <= 1'b1;
                    if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 8'd1;
                end
            end
        end
    end

    assign firStartOut = fir_start_q;
    assign firDataOut  = fir_data_q;
    assign coefWeOut   = coef_we_q;
    assign coefAddrOut = coef_addr_q;
    assign coefDataOut = coef_data_q;
    assign responseOut = response_q;
    assign busyOut     = (state_q != S_IDLE) || pend_valid_q;

endmodule

// File: tb/tb_fir_command_sequencer.sv
// Bench for fir_command_sequencer: a queue-based command model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_fir_command_sequencer;
    localparam int TIMEOUT = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic        done = 1'b0;
    logic [63:0] pkt_in = '0;
    logic [63:0] result = '0;
    logic        firStartOut;
    logic [31:0] firDataOut;
    logic        coefWeOut;
    logic [5:0]  coefAddrOut;
    logic [15:0] coefDataOut;
    logic [63:0] responseOut;
    logic        busyOut;

    fir_command_sequencer #(
        .PACKET_SIZE(8),
        .SAMPLES_NUM(2),
        .SAMPLE_WIDTH(16),
        .COEF_ADDR_WIDTH(6),
        .COEF_NUM(64),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clkIn(clk),
        .nResetIn(rst_n),
        .packetValidIn(valid),
        .packetIn(pkt_in),
        .firStartOut(firStartOut),
        .firDataOut(firDataOut),
        .firDoneIn(done),
        .firResultIn(result),
        .coefWeOut(coefWeOut),
        .coefAddrOut(coefAddrOut),
        .coefDataOut(coefDataOut),
        .responseOut(responseOut),
        .busyOut(busyOut)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int pulse_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Model: one executing command with its age in cycles since acceptance,
    // plus a queue holding at most one waiting packet.
    bit          m_active;
    int          m_kind;
    int          m_age;
    logic [63:0] m_q[$];
    logic [31:0] m_fdata;
    logic [5:0]  m_caddr;
    logic [15:0] m_cdata;
    logic [63:0] m_resp;
    bit          m_ovr, m_ill, m_to;
    int          m_frames, m_drops, m_ills;

    task automatic model_reset();
        m_active = 0; m_kind = 0; m_age = 0; m_q.delete();
        m_fdata = '0; m_caddr = '0; m_cdata = '0; m_resp = '0;
        m_ovr = 0; m_ill = 0; m_to = 0;
        m_frames = 0; m_drops = 0; m_ills = 0;
    endtask

    task automatic model_illegal();
        m_ill = 1;
        if (m_ills < 255) m_ills++;
    endtask

    task automatic model_exec(input logic [63:0] c, input bit pend);
        logic [7:0] op;
        logic [7:0] a;
        op = c[63:56];
        a  = c[55:48];
        case (op)
            8'h01: begin
                m_fdata = c[47:16];
                m_active = 1; m_kind = 1; m_age = 1;
            end
            8'h02: begin
                if (a < 8'd64) begin
                    m_caddr = a[5:0];
                    m_cdata = c[47:32];
                    m_active = 1; m_kind = 2; m_age = 1;
                end else begin
                    model_illegal();
                end
            end
            8'h03: begin
                m_resp = {8'h5A, 4'h0, pend, m_to, m_ill, m_ovr,
                          16'(m_frames), 8'(m_drops), 8'(m_ills), 16'h0000};
                m_active = 1; m_kind = 3; m_age = 1;
            end
            8'h04: begin
                m_ovr = 0; m_ill = 0; m_to = 0;
                m_frames = 0; m_drops = 0; m_ills = 0;
                m_resp = '0;
            end
            default: model_illegal();
        endcase
    endtask

    task automatic model_step();
        int          qs;
        logic [63:0] c;
        bit          have;
        qs   = m_q.size();
        have = 0;
        c    = '0;
        if (m_active) begin
            if (m_kind == 1) begin
                if (m_age >= 2) begin
                    if (done) begin
                        m_resp = result;
                        m_frames = (m_frames + 1) % 65536;
                        m_active = 0;
                    end else if (m_age - 2 == TIMEOUT - 1) begin
                        m_to = 1;
                        m_active = 0;
                    end
                end
            end else begin
                m_active = 0;
            end
            m_age++;
            if (valid) begin
                if (qs == 0) m_q.push_back(pkt_in);
                else begin
                    m_ovr = 1;
                    if (m_drops < 255) m_drops++;
                end
            end
        end else begin
            if (qs != 0) begin
                c = m_q.pop_front();
                have = 1;
                if (valid) m_q.push_back(pkt_in);
            end else if (valid) begin
                c = pkt_in;
                have = 1;
            end
            if (have) model_exec(c, qs != 0);
        end
    endtask

    always @(posedge clk) if (rst_n) model_step();
    always @(negedge rst_n) model_reset();
    always @(posedge clk) if (rst_n && (firStartOut || coefWeOut)) pulse_total++;

    always @(negedge clk) begin
        if (rst_n) begin
            chk("firStart", 64'(firStartOut), 64'(m_active && m_kind == 1 && m_age == 1));
            chk("coefWe", 64'(coefWeOut), 64'(m_active && m_kind == 2 && m_age == 1));
            chk("firData", 64'(firDataOut), 64'(m_fdata));
            chk("coefAddr", 64'(coefAddrOut), 64'(m_caddr));
            chk("coefData", 64'(coefDataOut), 64'(m_cdata));
            chk("response", responseOut, m_resp);
            chk("busy", 64'(busyOut), 64'(m_active || m_q.size() != 0));
        end
    end

    // All drivers assume they are called at a falling edge and return at one.
    task automatic send(input logic [63:0] p);
        valid = 1'b1;
        pkt_in = p;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic pulse_done(input logic [63:0] r);
        done = 1'b1;
        result = r;
        @(negedge clk);
        done = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        valid = 1'b0;
        done = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    localparam logic [63:0] STATUS = 64'h0300_0000_0000_0000;
    localparam logic [63:0] CLEAR  = 64'h0400_0000_0000_0000;

    int base;

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        chk("rst_response", responseOut, 64'h0);
        chk("rst_busy", 64'(busyOut), 64'h0);
        chk("rst_firData", 64'(firDataOut), 64'h0);
        pulse_done(64'hDEAD_BEEF_DEAD_BEEF);
        chk("stray_done_ignored", responseOut, 64'h0);

        // Basic filter frame with its cycle-exact latency.
        send(64'h0100_1234_ABCD_0000);
        chk("f_start_n1", 64'(firStartOut), 64'h1);
        chk("f_data", 64'(firDataOut), 64'h1234ABCD);
        @(negedge clk);
        chk("f_start_n2", 64'(firStartOut), 64'h0);
        repeat (3) @(negedge clk);
        pulse_done(64'h0011_2233_4455_6677);
        chk("f_response", responseOut, 64'h0011_2233_4455_6677);
        chk("f_busy_low", 64'(busyOut), 64'h0);

        // Coefficient write, then an out-of-range address.
        do_reset();
        send(64'h0205_7FFF_0000_0000);
        chk("cw_we", 64'(coefWeOut), 64'h1);
        chk("cw_addr", 64'(coefAddrOut), 64'h5);
        chk("cw_data", 64'(coefDataOut), 64'h7FFF);
        @(negedge clk);
        chk("cw_we_off", 64'(coefWeOut), 64'h0);
        send(64'h0240_1111_0000_0000);
        chk("cw_bad_no_we", 64'(coefWeOut), 64'h0);
        chk("cw_addr_held", 64'(coefAddrOut), 64'h5);
        send(STATUS);
        chk("cw_status", responseOut, 64'h5A02_0000_0001_0000);

        // Three filters back to back: second queued, third dropped.
        do_reset();
        send(64'h0100_0001_0002_0000);
        send(64'h0100_0003_0004_0000);
        send(64'h0100_0005_0006_0000);
        repeat (2) @(negedge clk);
        pulse_done(64'h1111_1111_1111_1111);
        repeat (4) @(negedge clk);
        pulse_done(64'h2222_2222_2222_2222);
        chk("q_second_resp", responseOut, 64'h2222_2222_2222_2222);
        send(STATUS);
        chk("q_status", responseOut, 64'h5A01_0002_0100_0000);

        // Watchdog timeout, then CLEAR.
        do_reset();
        send(64'h0100_5555_6666_0000);
        repeat (TIMEOUT + 6) @(negedge clk);
        chk("to_idle", 64'(busyOut), 64'h0);
        send(STATUS);
        chk("to_status", responseOut, 64'h5A04_0000_0000_0000);
        @(negedge clk);
        send(CLEAR);
        chk("clr_response", responseOut, 64'h0);
        send(STATUS);
        chk("clr_status", responseOut, 64'h5A00_0000_0000_0000);

        // Illegal opcode flood saturates the counter.
        do_reset();
        base = pulse_total;
        for (int i = 0; i < 300; i++) begin
            valid = 1'b1;
            pkt_in = 64'hFF00_0000_0000_0000;
            @(negedge clk);
        end
        valid = 1'b0;
        @(negedge clk);
        send(STATUS);
        chk("ill_status", responseOut, 64'h5A02_0000_00FF_0000);
        chk("ill_no_pulses", 64'(pulse_total - base), 64'h0);

        // Reset during WAIT_DONE discards the in-flight frame.
        do_reset();
        send(64'h0100_7777_8888_0000);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        base = pulse_total;
        @(negedge clk);
        pulse_done(64'hCAFE_CAFE_CAFE_CAFE);
        repeat (2) @(negedge clk);
        chk("mr_response", responseOut, 64'h0);
        chk("mr_busy", 64'(busyOut), 64'h0);
        chk("mr_no_pulses", 64'(pulse_total - base), 64'h0);
        send(STATUS);
        chk("mr_status", responseOut, 64'h5A00_0000_0000_0000);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
